// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the CPU data-memory interface. It takes one
//   LW/SW request at a time, waits WAIT_CYCLES wait states and then completes
//   the request with a single-cycle ready pulse. Storage is a word-organised
//   array of 2**DEPTH_LOG2 32-bit words. A misaligned address, or both strobes
//   raised together, is reported with err_o alongside ready_o. Such a request
//   does not write the array and returns zero read data.
//
// Parameters
//   DEPTH_LOG2   log2 of the number of 32-bit words
//   WAIT_CYCLES  wait states between accept and ready (0..15)
//
// Ports
//   clk_i     in   1   clock, rising edge
//   rst_n_i   in   1   asynchronous active-low reset
//   mem_rd_i  in   1   read request (LW)
//   mem_wr_i  in   1   write request (SW)
//   addr_i    in   32  byte address; only the word index bits are used
//   wdata_i   in   32  write data
//   rdata_o   out  32  read data, nonzero only while ready_o=1
//   ready_o   out  1   single-cycle completion pulse
//   busy_o    out  1   high while a request is waiting or responding
//   err_o     out  1   single-cycle illegal-request pulse, with ready_o
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;

    // Request captured at accept time
    logic [DEPTH_LOG2-1:0]   idx;
    logic [31:0]             wdata;
    logic                    wr;
    logic                    err;

    logic [31:0]             mem [DEPTH];

    logic                    req;
    logic                    in_err;
    logic [DEPTH_LOG2-1:0]   in_idx;
    logic                    unused_addr;

    assign req    = mem_rd_i | mem_wr_i;
    assign in_err = (addr_i[1:0] != 2'b00) | (mem_rd_i & mem_wr_i);
    assign in_idx = addr_i[DEPTH_LOG2+1:2];

    // Upper address bits are deliberately ignored: the address wraps modulo
    // the array depth.
    assign unused_addr = ^addr_i[31:DEPTH_LOG2+2];

    // Read data only for a legal read; writes and illegal requests return 0.
    function automatic logic [31:0] load_value(input logic is_wr,
                                               input logic is_err,
                                               input logic [31:0] word);
        return (is_wr || is_err) ? 32'd0 : word;
    endfunction

    // Operand capture. Not reset: these are only consumed after an accept.
    always_ff @(posedge clk_i) begin
        if (state == S_IDLE && req) begin
            idx   <= in_idx;
            wdata <= wdata_i;
        end
    end

    // Array write at the RESP->IDLE edge. A reset forces state to IDLE
    // asynchronously, so an aborted request can never reach this write.
    always_ff @(posedge clk_i) begin
        if (state == S_RESP && wr && !err) begin
            mem[idx] <= wdata;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            wr      <= 1'b0;
            err     <= 1'b0;
            rdata_o <= 32'd0;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                    rdata_o <= 32'd0;
                    if (req) begin
                        cnt    <= 4'(WAIT_CYCLES);
                        wr     <= mem_wr_i & ~mem_rd_i;
                        err    <= in_err;
                        busy_o <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            // No wait states: respond straight from the
                            // inputs, since the captured copy is not yet valid.
                            state   <= S_RESP;
                            ready_o <= 1'b1;
                            err_o   <= in_err;
                            rdata_o <= load_value(mem_wr_i, in_err, mem[in_idx]);
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        busy_o <= 1'b0;
                    end
                end

                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state   <= S_RESP;
                        ready_o <= 1'b1;
                        err_o   <= err;
                        rdata_o <= load_value(wr, err, mem[idx]);
                    end
                end

                S_RESP: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                    busy_o  <= 1'b0;
                    rdata_o <= 32'd0;
                end

                default: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                    busy_o  <= 1'b0;
                    rdata_o <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Bench for data_mem_responder. One instance uses the default two wait
//   states, and a second instance uses zero wait states for back-to-back
//   timing. Expected values come from a word-array model of the memory and
//   from the request rules: word index from address bits, illegal requests,
//   and latency WAIT_CYCLES+1 sampling points after the accept edge.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DL2 = 6;
    localparam int W2  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        mem_rd = 1'b0, mem_wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ready, busy, err;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [31:0] rdata0;
    logic        ready0, busy0, err0;

    int tests = 0;
    int failed = 0;

    logic [31:0] model [64];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(W2)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .ready_o(ready), .busy_o(busy), .err_o(err)
    );

    data_mem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .mem_rd_i(rd0), .mem_wr_i(wr0),
        .addr_i(addr0), .wdata_i(wdata0),
        .rdata_o(rdata0), .ready_o(ready0), .busy_o(busy0), .err_o(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request on the two-wait-state instance, checked against
    // the model; the model is updated for legal writes.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
        logic       exp_err;
        int         i;
        int         n;
        logic       got;
        logic       busy_ok;
        exp_err = (a[1:0] != 2'b00) || (rd && wr);
        i       = int'(a[7:2]);
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
        @(posedge clk);
        n = 0; got = 1'b0; busy_ok = 1'b1;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (ready) got = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check({tag, " latency"}, n, W2 + 1);
        check({tag, " busy_wait"}, busy_ok, 1'b1);
        check({tag, " busy_resp"}, busy, 1'b1);
        check({tag, " err"}, err, exp_err);
        if (exp_err) check({tag, " rdata_err"}, rdata, 32'd0);
        else if (rd) check({tag, " rdata"}, rdata, model[i]);
        mem_rd = 1'b0; mem_wr = 1'b0;
        if (wr && !rd && !exp_err) model[i] = d;
        @(negedge clk);
        check({tag, " ready_idle"}, ready, 1'b0);
        check({tag, " busy_idle"}, busy, 1'b0);
        check({tag, " rdata_idle"}, rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        int          op;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst rdata", rdata, 32'd0);
        check("rst ready", ready, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst err", err, 1'b0);
        check("rst0 busy", busy0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill every word so the model is fully known; upper address bits
        // are randomised to exercise wrap-around.
        for (int k = 0; k < 64; k++) begin
            v = $urandom;
            a = {$urandom} & 32'hFFFF_FF00;
            a = a | (k << 2);
            req(1'b0, 1'b1, a, v, "fill");
        end

        // Reset in the middle of a write's wait states
        @(negedge clk);
        mem_wr = 1'b1; addr = 32'h10; wdata = 32'hA5A5_5A5A ^ model[4];
        @(posedge clk);
        @(negedge clk);
        check("t1 busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t1 rst rdata", rdata, 32'd0);
        check("t1 rst ready", ready, 1'b0);
        check("t1 rst busy", busy, 1'b0);
        check("t1 rst err", err, 1'b0);
        mem_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req(1'b1, 1'b0, 32'h10, 32'h0, "t1 read_old");

        // Write then read
        req(1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, "t2 sw");
        req(1'b1, 1'b0, 32'h0000_0008, 32'h0, "t2 lw");
        check("t2 model", model[2], 32'hDEAD_BEEF);

        // Wrap-around: 0x100 and 0x000 share index 0
        req(1'b0, 1'b1, 32'h0000_0100, 32'h0000_1234, "t3 sw");
        req(1'b1, 1'b0, 32'h0000_0000, 32'h0, "t3 lw");

        // Misaligned accesses
        req(1'b1, 1'b0, 32'h0000_0006, 32'h0, "t4 lw_mis");
        req(1'b0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF, "t4 sw_mis");
        req(1'b1, 1'b0, 32'h0000_0004, 32'h0, "t4 lw4");
        req(1'b1, 1'b0, 32'h0000_0008, 32'h0, "t4 lw8");

        // Both strobes
        req(1'b1, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, "t5 both");
        req(1'b1, 1'b0, 32'h0000_0020, 32'h0, "t5 lw");

        // Randomised mix
        for (int k = 0; k < 40; k++) begin
            a  = {$urandom};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            op = int'($urandom_range(0, 9));
            v  = $urandom;
            if (op < 5)       req(1'b1, 1'b0, a, v, "rnd lw");
            else if (op < 9)  req(1'b0, 1'b1, a, v, "rnd sw");
            else              req(1'b1, 1'b1, a, v, "rnd both");
        end

        // Back-to-back with zero wait states: strobe held, ready every 2 cycles
        v = $urandom;
        @(negedge clk);
        wr0 = 1'b1; addr0 = 32'h40; wdata0 = v;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6 wr ready", ready0, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t6 wr busy", busy0, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t6 wr err", err0, 1'b0);
        end
        wr0 = 1'b0; rd0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t6 rd ready", ready0, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t6 rd busy", busy0, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t6 rd rdata", rdata0, (k % 2 == 0) ? v : 32'd0);
        end
        rd0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6 idle busy", busy0, 1'b0);
        check("t6 idle ready", ready0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
